priority_decoder32: RTL and testbench

- Sequential inverse of the 32-input priority encoder: accepts a stream of 5-bit indices and produces registered decoded vectors.
- Each output beat carries the canonical one-hot code, the thermometer "don't-care" mask, and a snapshot of a persistent 32-bit mask register.
- SET/CLEAR/TOGGLE commands edit the mask register, which is typically fed back into the priority encoder as a request vector.
- Sits between the arbitration/encoding stage and downstream grant logic, with valid/ready on both sides.

---
 rtl/priority_pkg.sv | 25 ++
 rtl/pd_line_decode.sv | 29 ++
 rtl/priority_decoder32.sv | 120 ++++++++++++
 tb/tb_priority_decoder32.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared op encoding, default sizes and clog2 for the priority encoder/decoder family
package priority_pkg;

    localparam int PD_WIDTH = 32;
    localparam int PD_IDX_W = 5;

    typedef enum logic [1:0] {
        OP_DECODE = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } pd_op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pd_line_decode.sv
// rtl/pd_line_decode.sv - combinational index to one-hot / thermometer / range-error decode
module pd_line_decode
    import priority_pkg::*;
#(
    parameter int WIDTH = PD_WIDTH,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [WIDTH-1:0] therm_o,
    output logic             err_o
);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(idx_i);

    // Out-of-range indices fall out naturally: no line matches, every line is below.
    always_comb begin
        onehot_o = '0;
        therm_o  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot_o[i] = (idx_ext == 32'(i));
            therm_o[i]  = (idx_ext >= 32'(i));
        end
        err_o = (idx_ext >= 32'(WIDTH));
    end

endmodule

// File: rtl/priority_decoder32.sv
// rtl/priority_decoder32.sv - registered index decoder with persistent editable mask and popcount
module priority_decoder32
    import priority_pkg::*;
#(
    parameter int WIDTH = PD_WIDTH,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [WIDTH-1:0] out_therm,
    output logic [WIDTH-1:0] out_mask,
    output logic             out_err,
    output logic [WIDTH-1:0] mask,
    output logic [IDX_W:0]   mask_cnt
);

    localparam logic [IDX_W:0] CNT_ONE = IDX_W'(1);

    logic [WIDTH-1:0] dec_onehot;
    logic [WIDTH-1:0] dec_therm;
    logic             dec_err;

    logic             accept;
    logic             bit_set;
    logic             bit_live;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_onehot_q;
    logic [WIDTH-1:0] out_therm_q;
    logic [WIDTH-1:0] out_mask_q;
    logic             out_err_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDX_W:0]   cnt_q, cnt_d;

    pd_line_decode #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_line_decode (
        .idx_i   (in_idx),
        .onehot_o(dec_onehot),
        .therm_o (dec_therm),
        .err_o   (dec_err)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Mask state comes straight from the register, so consecutive edits chain correctly.
    assign bit_live = |dec_onehot;
    assign bit_set  = |(mask_q & dec_onehot);

    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        unique case (pd_op_e'(in_op))
            OP_SET: begin
                mask_d = mask_q | dec_onehot;
                if (bit_live && !bit_set) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            OP_CLEAR: begin
                mask_d = mask_q & ~dec_onehot;
                if (bit_set) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            OP_TOGGLE: begin
                mask_d = mask_q ^ dec_onehot;
                if (bit_set) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (bit_live) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                mask_d = mask_q;
                cnt_d  = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_therm_q  <= '0;
            out_mask_q   <= '0;
            out_err_q    <= 1'b0;
            mask_q       <= '0;
            cnt_q        <= '0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_onehot_q <= dec_onehot;
            out_therm_q  <= dec_therm;
            out_mask_q   <= mask_d;
            out_err_q    <= dec_err;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_therm  = out_therm_q;
    assign out_mask   = out_mask_q;
    assign out_err    = out_err_q;
    assign mask       = mask_q;
    assign mask_cnt   = cnt_q;

endmodule

// File: tb/tb_priority_decoder32.sv
// tb/tb_priority_decoder32.sv - self-checking bench for priority_decoder32 (32-wide and 24-wide instances)
module tb_priority_decoder32;

    localparam int W = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_idx;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_onehot;
    logic [31:0] out_therm;
    logic [31:0] out_mask;
    logic        out_err;
    logic [31:0] mask;
    logic [5:0]  mask_cnt;

    logic        in_valid_24;
    logic        in_ready_24;
    logic [4:0]  in_idx_24;
    logic [1:0]  in_op_24;
    logic        out_valid_24;
    logic        out_ready_24;
    logic [23:0] out_onehot_24;
    logic [23:0] out_therm_24;
    logic [23:0] out_mask_24;
    logic        out_err_24;
    logic [23:0] mask_24;
    logic [5:0]  mask_cnt_24;

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid;
    logic [31:0] m_onehot;
    logic [31:0] m_therm;
    logic [31:0] m_omask;
    bit          m_err;
    logic [31:0] m_mask;

    priority_decoder32 #(.WIDTH(32), .IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_therm(out_therm), .out_mask(out_mask),
        .out_err(out_err), .mask(mask), .mask_cnt(mask_cnt)
    );

    priority_decoder32 #(.WIDTH(24), .IDX_W(5)) dut24 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_24), .in_ready(in_ready_24), .in_idx(in_idx_24), .in_op(in_op_24),
        .out_valid(out_valid_24), .out_ready(out_ready_24),
        .out_onehot(out_onehot_24), .out_therm(out_therm_24), .out_mask(out_mask_24),
        .out_err(out_err_24), .mask(mask_24), .mask_cnt(mask_cnt_24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_onehot = '0;
        m_therm  = '0;
        m_omask  = '0;
        m_err    = 1'b0;
        m_mask   = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_onehot"}, out_onehot, m_onehot);
        chk({tag, ".out_therm"}, out_therm, m_therm);
        chk({tag, ".out_mask"}, out_mask, m_omask);
        chk({tag, ".out_err"}, 32'(out_err), 32'(m_err));
        chk({tag, ".mask"}, mask, m_mask);
        chk({tag, ".mask_cnt"}, 32'(mask_cnt), 32'($countones(m_mask)));
    endtask

    // Called at a negedge: drive, check in_ready, apply one clock, check outputs at the next negedge.
    task automatic cycle(input string tag, input bit v, input logic [1:0] op,
                         input logic [4:0] idx, input bit rdy);
        bit          acc;
        logic [63:0] bitv;
        logic [31:0] oh;
        in_valid  = v;
        in_op     = op;
        in_idx    = idx;
        out_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || rdy));
        acc = v && (!m_valid || rdy);
        if (acc) begin
            bitv = (int'(idx) < W) ? (64'd1 << idx) : 64'd0;
            oh   = bitv[31:0];
            case (op)
                2'b01:   m_mask = m_mask | oh;
                2'b10:   m_mask = m_mask & ~oh;
                2'b11:   m_mask = m_mask ^ oh;
                default: m_mask = m_mask;
            endcase
            m_valid  = 1'b1;
            m_onehot = oh;
            m_therm  = (int'(idx) >= W) ? 32'hFFFF_FFFF : 32'((64'd1 << (int'(idx) + 1)) - 64'd1);
            m_omask  = m_mask;
            m_err    = (int'(idx) >= W);
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [4:0] hold_idx;
        rst = 1'b1;
        in_valid = 1'b0; in_idx = '0; in_op = '0; out_ready = 1'b1;
        in_valid_24 = 1'b0; in_idx_24 = '0; in_op_24 = '0; out_ready_24 = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        cycle("dec0", 1, 2'b00, 5'd0, 1);
        cycle("dec31", 1, 2'b00, 5'd31, 1);
        cycle("dec17", 1, 2'b00, 5'd17, 1);
        chk("dec17.onehot_abs", out_onehot, 32'h0002_0000);
        chk("dec17.therm_abs", out_therm, 32'h0003_FFFF);

        cycle("set3", 1, 2'b01, 5'd3, 1);
        cycle("set3b", 1, 2'b01, 5'd3, 1);
        cycle("set31", 1, 2'b01, 5'd31, 1);
        chk("set31.mask_abs", mask, 32'h8000_0008);
        cycle("clr3", 1, 2'b10, 5'd3, 1);
        cycle("tog31", 1, 2'b11, 5'd31, 1);
        cycle("tog0", 1, 2'b11, 5'd0, 1);
        chk("tog0.cnt_abs", 32'(mask_cnt), 32'd1);

        for (int i = 0; i < 32; i++) cycle("setall", 1, 2'b01, 5'(i), 1);
        chk("setall.mask_abs", mask, 32'hFFFF_FFFF);
        chk("setall.cnt_abs", 32'(mask_cnt), 32'd32);
        for (int i = 0; i < 32; i++) cycle("clrall", 1, 2'b10, 5'(i), 1);
        chk("clrall.cnt_abs", 32'(mask_cnt), 32'd0);

        for (int i = 0; i < 4; i++) cycle("bp_hold", 1, 2'b01, 5'd5, 0);
        cycle("bp_acc", 1, 2'b01, 5'd5, 1);
        chk("bp_acc.out_mask_abs", out_mask, 32'h0000_0020);

        cycle("pre_rst_set7", 1, 2'b01, 5'd7, 0);
        cycle("pre_rst_set7b", 1, 2'b01, 5'd7, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst_dec4", 1, 2'b00, 5'd4, 1);
        cycle("post_rst_set9", 1, 2'b01, 5'd9, 1);

        for (int n = 0; n < 400; n++) begin
            hold_idx = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle("rand", bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), hold_idx,
                  bit'($urandom_range(0, 3) != 0));
        end

        in_valid = 1'b0;
        in_valid_24 = 1'b1; in_op_24 = 2'b00; in_idx_24 = 5'd27; out_ready_24 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("w24_dec27.out_valid", 32'(out_valid_24), 32'd1);
        chk("w24_dec27.out_err", 32'(out_err_24), 32'd1);
        chk("w24_dec27.out_onehot", 32'(out_onehot_24), 32'd0);
        chk("w24_dec27.out_therm", 32'(out_therm_24), 32'h00FF_FFFF);
        in_op_24 = 2'b01;
        @(posedge clk); @(negedge clk);
        chk("w24_set27.mask", 32'(mask_24), 32'd0);
        chk("w24_set27.out_mask", 32'(out_mask_24), 32'd0);
        chk("w24_set27.mask_cnt", 32'(mask_cnt_24), 32'd0);
        chk("w24_set27.out_err", 32'(out_err_24), 32'd1);
        in_idx_24 = 5'd23;
        @(posedge clk); @(negedge clk);
        chk("w24_set23.out_onehot", 32'(out_onehot_24), 32'h0080_0000);
        chk("w24_set23.out_err", 32'(out_err_24), 32'd0);
        chk("w24_set23.mask", 32'(mask_24), 32'h0080_0000);
        chk("w24_set23.mask_cnt", 32'(mask_cnt_24), 32'd1);
        in_valid_24 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
